// File: rtl/alu_operand_sequencer.sv
// Multicycle control FSM: drives ALU operand selects, ALU op and datapath write enables.
// Optional overflow trap compiled in with `define OVERFLOW_TRAP_EN.
module alu_operand_sequencer #(
  parameter int MEM_WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_on_zero,
  output logic [1:0] pc_source,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       a_b_write,
  output logic       alu_out_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       epc_write,
  output logic [1:0] cause
);

  typedef enum logic [3:0] {
    RST, FETCH, DECODE, EXEC_R, R_WB, EXEC_I, I_WB, MEM_ADDR,
    MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, EXC
  } state_t;

  localparam logic [2:0] OP_IDLE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_J     = 6'h02;

  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT_CYCLES);

  state_t     state, next_state;
  logic [2:0] wait_cnt;
  logic       wait_done;
  logic [1:0] next_cause;
  logic       mem_is_load;
  logic       branch_eq;
  logic [2:0] funct_op;
  logic       funct_ok;
  logic       funct_arith;
  logic       ovf_trap;
  logic       unused_inputs;

  // Branch resolution happens in the datapath via pc_write_cond/branch_on_zero.
`ifdef OVERFLOW_TRAP_EN
  assign ovf_trap      = alu_overflow;
  assign unused_inputs = alu_zero;
`else
  assign ovf_trap      = 1'b0;
  assign unused_inputs = alu_zero ^ alu_overflow;
`endif

  assign wait_done = (wait_cnt == WAIT_LAST);

  always_comb begin
    funct_op    = OP_IDLE;
    funct_ok    = 1'b1;
    funct_arith = 1'b0;
    case (funct)
      6'h20:   begin funct_op = OP_ADD; funct_arith = 1'b1; end
      6'h22:   begin funct_op = OP_SUB; funct_arith = 1'b1; end
      6'h24:   funct_op = OP_AND;
      6'h25:   funct_op = OP_OR;
      6'h2A:   funct_op = OP_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RST;
      wait_cnt    <= 3'd0;
      cause       <= 2'b00;
      mem_is_load <= 1'b0;
      branch_eq   <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= (next_state != state) ? 3'd0 : wait_cnt + 3'd1;
      if (next_state == EXC) cause <= next_cause;
      // Opcode is only trusted while the IR is known stable in DECODE.
      if (state == DECODE) begin
        mem_is_load <= (opcode == OPC_LW);
        branch_eq   <= (opcode == OPC_BEQ);
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    next_cause = 2'b00;
    case (state)
      RST:    next_state = FETCH;
      FETCH:  if (wait_done) next_state = DECODE;
      DECODE: begin
        case (opcode)
          OPC_RTYPE:        next_state = EXEC_R;
          OPC_ADDI:         next_state = EXEC_I;
          OPC_LW, OPC_SW:   next_state = MEM_ADDR;
          OPC_BEQ, OPC_BNE: next_state = BRANCH;
          OPC_J:            next_state = JUMP;
          default: begin
            next_state = EXC;
            next_cause = CAUSE_ILLEGAL;
          end
        endcase
      end
      EXEC_R: begin
        if (!funct_ok) begin
          next_state = EXC;
          next_cause = CAUSE_ILLEGAL;
        end else if (ovf_trap && funct_arith) begin
          next_state = EXC;
          next_cause = CAUSE_OVERFLOW;
        end else begin
          next_state = R_WB;
        end
      end
      EXEC_I: begin
        if (ovf_trap) begin
          next_state = EXC;
          next_cause = CAUSE_OVERFLOW;
        end else begin
          next_state = I_WB;
        end
      end
      MEM_ADDR: next_state = mem_is_load ? MEM_RD : MEM_WR;
      MEM_RD:   if (wait_done) next_state = MEM_WB;
      R_WB, I_WB, MEM_WB, MEM_WR, BRANCH, JUMP, EXC: next_state = FETCH;
      default:  next_state = RST;
    endcase
  end

  always_comb begin
    alu_src_a      = 1'b0;
    alu_src_b      = 2'b00;
    alu_op         = OP_IDLE;
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    branch_on_zero = 1'b0;
    pc_source      = 2'b00;
    ir_write       = 1'b0;
    i_or_d         = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    a_b_write      = 1'b0;
    alu_out_write  = 1'b0;
    reg_write      = 1'b0;
    reg_dst        = 1'b0;
    mem_to_reg     = 1'b0;
    epc_write      = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = OP_ADD;
        ir_write  = wait_done;
        pc_write  = wait_done;
      end
      DECODE: begin
        alu_src_b     = 2'b11;
        alu_op        = OP_ADD;
        alu_out_write = 1'b1;
        a_b_write     = 1'b1;
      end
      EXEC_R: begin
        alu_src_a     = 1'b1;
        alu_op        = funct_op;
        alu_out_write = 1'b1;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      EXEC_I, MEM_ADDR: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b10;
        alu_op        = OP_ADD;
        alu_out_write = 1'b1;
      end
      I_WB: reg_write = 1'b1;
      MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a      = 1'b1;
        alu_op         = OP_SUB;
        pc_write_cond  = 1'b1;
        pc_source      = 2'b01;
        branch_on_zero = branch_eq;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      EXC: begin
        alu_src_b = 2'b01;
        alu_op    = OP_SUB;
        epc_write = 1'b1;
        pc_write  = 1'b1;
        pc_source = 2'b11;
      end
      default: ;
    endcase
  end

endmodule
